// File: rtl/timer_scheduler.sv
// Round-robin scheduler that time-shares one external delay counter among
// several requesters. A granted requester gets its delay loaded into the
// counter, and receives a one-cycle done pulse when the counter expires.
module timer_scheduler #(
  parameter int unsigned width = 5,
  parameter int unsigned reqs  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [reqs-1:0]         req,
  input  logic [reqs*width-1:0]   dly,
  output logic [reqs-1:0]         gnt,
  output logic [reqs-1:0]         done,
  output logic                    busy,
  output logic                    ctr_ld,
  output logic [width-1:0]        ctr_nb,
  input  logic                    ctr_dn
);

  localparam int unsigned IdxW = (reqs > 1) ? $clog2(reqs) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWait,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] g_q, g_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [width-1:0] k_q, k_d;

  logic            found;
  logic [IdxW-1:0] pick;
  logic [IdxW-1:0] cand;
  logic [width-1:0] k_pick;

  // Increment a requester index, wrapping from reqs-1 back to 0.
  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] v);
    if (v == IdxW'(reqs - 1)) return '0;
    return v + IdxW'(1);
  endfunction

  // Round-robin search: first requesting index at or after ptr, plus its delay.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    k_pick = '0;
    cand   = ptr_q;
    for (int unsigned i = 0; i < reqs; i++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = wrap_inc(cand);
    end
    for (int unsigned i = 0; i < reqs; i++) begin
      if (pick == IdxW'(i)) k_pick = dly[i*width +: width];
    end
  end

  // Next-state logic: grant, load, wait for expiry or abort, then complete.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StLoad;
          g_d     = pick;
          k_d     = k_pick;
        end
      end
      StLoad: state_d = StWait;
      StWait: begin
        // A dropped request wins over a simultaneous counter expiry.
        if (!req[g_q]) begin
          state_d = StIdle;
          ptr_d   = wrap_inc(g_q);
        end else if (ctr_dn) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        ptr_d   = wrap_inc(g_q);
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; reset forces a counter clear since the counter has no reset.
  always_comb begin
    gnt    = '0;
    done   = '0;
    busy   = (state_q != StIdle);
    ctr_ld = 1'b0;
    ctr_nb = '0;
    if (rst) begin
      ctr_ld = 1'b1;
      ctr_nb = '0;
    end else if (state_q == StLoad) begin
      // ~k makes the counter fire k+width edges after the load edge.
      ctr_ld = 1'b1;
      ctr_nb = ~k_q;
    end
    if (state_q != StIdle) gnt[g_q] = 1'b1;
    if (state_q == StDone) done[g_q] = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      g_q     <= '0;
      ptr_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: a stand-in delay counter, a timing-based
// reference model checked every cycle, directed scenarios with literal
// expectations, then a randomized phase.
module tb_timer_scheduler;

  localparam int W  = 5;
  localparam int R  = 4;
  localparam int DW = W * R;

  logic          clk = 1'b0;
  logic          rst;
  logic [R-1:0]  req;
  logic [DW-1:0] dly;
  logic [R-1:0]  gnt;
  logic [R-1:0]  done;
  logic          busy;
  logic          ctr_ld;
  logic [W-1:0]  ctr_nb;
  logic          ctr_dn;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  timer_scheduler #(.width(W), .reqs(R)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .dly    (dly),
    .gnt    (gnt),
    .done   (done),
    .busy   (busy),
    .ctr_ld (ctr_ld),
    .ctr_nb (ctr_nb),
    .ctr_dn (ctr_dn)
  );

  always #5 clk = ~clk;

  // Counter stand-in: dn rises exactly (~nb)+W edges after the load edge, sticky.
  logic [W-1:0] knb;
  int           rem = 0;
  logic         dn_r = 1'b0;
  assign knb    = ~ctr_nb;
  assign ctr_dn = dn_r;
  always @(posedge clk) begin
    if (ctr_ld) begin
      rem  <= int'(knb) + W;
      dn_r <= 1'b0;
    end else if (rem > 1) begin
      rem <= rem - 1;
    end else if (rem == 1) begin
      rem  <= 0;
      dn_r <= 1'b1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference model: a job is (index g, grant edge t, delay d); everything
  // else follows from elapsed edges since t.
  bit           m_busy = 1'b0;
  int           m_g = 0, m_t = 0, m_d = 0, m_ptr = 0, ph = 0, c = 0;
  bit           m_found;
  logic [W-1:0] m_k = '0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
    end else if (!m_busy) begin
      m_found = 1'b0;
      for (int i = 0; i < R; i++) begin
        c = (m_ptr + i) % R;
        if (!m_found && req[c]) begin
          m_found = 1'b1;
          m_busy  = 1'b1;
          m_g     = c;
          m_k     = dly[c*W +: W];
          m_d     = int'(m_k) + W;
          m_t     = cyc;
        end
      end
    end else begin
      ph = cyc - m_t;
      if (ph >= 2 && ph <= m_d + 2 && !req[m_g]) begin
        m_busy = 1'b0;
        m_ptr  = (m_g + 1) % R;
      end else if (ph == m_d + 3) begin
        m_busy = 1'b0;
        m_ptr  = (m_g + 1) % R;
      end
    end
  end

  // Event logs for the directed checks.
  int           gnt_t[$], gnt_i[$], gnt_nb[$], gnt_ld[$], done_t[$], done_v[$], fall_t[$];
  logic [R-1:0] prev_gnt = '0;
  logic [R-1:0] e_gnt, e_done;
  logic         e_ld, e_busy;
  logic [W-1:0] e_nb;
  int           eph, gi;

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    eph    = cyc - m_t;
    e_gnt  = '0;
    e_done = '0;
    if (m_busy) e_gnt[m_g] = 1'b1;
    if (m_busy && eph == m_d + 2) e_done = e_gnt;
    e_busy = m_busy;
    e_ld   = rst || (m_busy && eph == 0);
    e_nb   = (!rst && m_busy && eph == 0) ? ~m_k : '0;
    total++;
    if ({gnt, done, busy, ctr_ld, ctr_nb} !== {e_gnt, e_done, e_busy, e_ld, e_nb}) begin
      bad++;
      $display("FAIL model cyc=%0d: got gnt=%b done=%b busy=%b ld=%b nb=%b want gnt=%b done=%b busy=%b ld=%b nb=%b",
               cyc, gnt, done, busy, ctr_ld, ctr_nb, e_gnt, e_done, e_busy, e_ld, e_nb);
    end
    if (gnt != '0 && prev_gnt == '0) begin
      gi = -1;
      for (int i = 0; i < R; i++) if (gnt[i]) gi = i;
      gnt_t.push_back(cyc);
      gnt_i.push_back(gi);
      gnt_nb.push_back(int'(ctr_nb));
      gnt_ld.push_back(int'(ctr_ld));
    end
    if (done != '0) begin
      done_t.push_back(cyc);
      done_v.push_back(int'(done));
    end
    if (gnt == '0 && prev_gnt != '0) fall_t.push_back(cyc);
    prev_gnt = gnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm, input int bound);
    int  n0;
    bit  ok;
    n0 = done_t.size();
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      if (done_t.size() > n0) ok = 1'b1;
    end
    if (!ok) chk({nm, " done timeout"}, 0, 1);
  endtask

  task automatic wait_gnt(input string nm, input int bound);
    int  n0;
    bit  ok;
    n0 = gnt_t.size();
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      if (gnt_t.size() > n0) ok = 1'b1;
    end
    if (!ok) chk({nm, " gnt timeout"}, 0, 1);
  endtask

  int order[6] = '{0, 1, 3, 0, 1, 3};
  int g0, d0, nd;

  initial begin
    rst = 1'b1;
    req = '0;
    dly = '0;

    // Reset held: counter cleared, scheduler idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst ld", int'(ctr_ld), 1);
      chk("rst nb", int'(ctr_nb), 0);
      chk("rst gnt+busy", int'({gnt, busy}), 0);
    end
    tick();
    rst = 1'b0;
    tick();

    // Single job: k=5 -> d=10, done at gnt+12, gnt falls at gnt+13.
    dly[0*W +: W] = 5'd5;
    req = 4'b0001;
    wait_done("single", 40);
    req = '0;
    tick();
    tick();
    if (gnt_t.size() > 0 && done_t.size() > 0 && fall_t.size() > 0) begin
      chk("single idx", gnt_i[$], 0);
      chk("single ld", gnt_ld[$], 1);
      chk("single nb", gnt_nb[$], 26);
      chk("single lat", done_t[$] - gnt_t[$], 12);
      chk("single done", done_v[$], 1);
      chk("single fall", fall_t[$] - done_t[$], 1);
    end else chk("single logged", 0, 1);

    // Contention from fresh pointer: order 0,1,3,0,1,3 with k=0 (d=5).
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dly = '0;
    g0 = gnt_t.size();
    d0 = done_t.size();
    req = 4'b1011;
    for (int j = 0; j < 6; j++) wait_done("contend", 40);
    req = '0;
    tick();
    if (gnt_t.size() >= g0 + 6 && done_t.size() >= d0 + 6) begin
      for (int j = 0; j < 6; j++) begin
        chk("contend order", gnt_i[g0+j], order[j]);
        chk("contend lat", done_t[d0+j] - gnt_t[g0+j], 7);
      end
      chk("k0 nb", gnt_nb[g0], 31);
    end else chk("contend logged", 0, 1);

    // Largest delay: k=31 -> done at gnt+38, nb all zero.
    dly[2*W +: W] = 5'd31;
    req = 4'b0100;
    wait_done("kmax", 80);
    req = '0;
    tick();
    chk("kmax lat", done_t[$] - gnt_t[$], 38);
    chk("kmax nb", gnt_nb[$], 0);

    // Abort: requester 2 drops 4 cycles after gnt, no done; 3 wins next.
    dly[2*W +: W] = 5'd10;
    dly[3*W +: W] = 5'd0;
    req = 4'b0100;
    wait_gnt("abort", 20);
    d0 = done_t.size();
    tick();
    tick();
    tick();
    req = '0;
    tick();
    tick();
    chk("abort gnt", int'(gnt), 0);
    for (int i = 0; i < 20; i++) tick();
    chk("abort no done", done_t.size(), d0);
    req = 4'b1100;
    wait_gnt("after abort", 20);
    chk("after abort idx", gnt_i[$], 3);
    wait_done("after abort", 40);
    req = '0;
    tick();

    // Reset mid-wait: move ptr to 2, start d=20 job, reset; 0 wins after.
    dly[1*W +: W] = 5'd0;
    req = 4'b0010;
    wait_done("pre-rst", 40);
    req = '0;
    tick();
    dly[2*W +: W] = 5'd15;
    req = 4'b0100;
    wait_gnt("midrst", 20);
    d0 = done_t.size();
    for (int i = 0; i < 8; i++) tick();
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    nd = done_t.size();
    chk("midrst no done", nd, d0);
    req = 4'b1001;
    wait_gnt("post-rst", 20);
    chk("post-rst idx", gnt_i[$], 0);
    wait_done("post-rst", 40);
    req = '0;
    tick();

    // Randomized traffic, dly churn, occasional reset; model checks every cycle.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < R; i++) if ($urandom_range(0, 23) == 0) req[i] = ~req[i];
      dly = DW'($urandom());
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < 5; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Shares one carry-save delay `counter` (ports `ld`, `nb`, `dn`) among several requesters. Each requester asks for a programmable delay. The scheduler arbitrates round-robin, loads the counter, waits for its done flag, and returns a one-cycle completion pulse to the granted requester. It sits between the client blocks and a single `counter` instance and drives that counter's load port exclusively.

## Interface
- `width`, default 5: counter width. Must be ≥ 2.
- `reqs`, default 4: number of requesters. Must be ≥ 1.
- `clk` input 1: clock; all state updates on posedge.
- `rst` input 1: reset, synchronous, active-high.
- `req` input `reqs`: per-requester request level.
- `dly` input `reqs*width`: per-requester delay offset `k`; slice i is `dly[i*width +: width]`. Requested delay is d = k + `width` cycles.
- `gnt` output `reqs`: one-hot grant; all-zero when idle.
- `done` output `reqs`: one-cycle completion pulse to the granted requester.
- `busy` output 1: high in every state except IDLE.
- `ctr_ld` output 1: drives `counter.ld`.
- `ctr_nb` output `width`: drives `counter.nb`.
- `ctr_dn` input 1: from `counter.dn`.

## Operation
- States: IDLE, LOAD, WAIT, DONE. State, grant, latched `k` and round-robin pointer `ptr` are all registered.
- **IDLE**
  - If any `req` bit is high, pick the first requester at or after `ptr` (wrapping) with `req` high.
  - Set `gnt` to that requester, latch its `k`, and go to LOAD.
  - If no request is present, stay in IDLE.
- **LOAD** (exactly one cycle)
  - `ctr_ld`=1 and `ctr_nb`=~k (bitwise complement, i.e. −(k+1) mod 2^width). This makes the counter raise `dn` exactly d = k+`width` edges after the load edge.
  - Go to WAIT.
- **WAIT**
  - `ctr_ld`=0.
  - If `req[g]` drops (g = granted index), abort: go to IDLE, clear `gnt`, no `done` pulse, `ptr`←g+1.
  - Otherwise, if `ctr_dn`=1, go to DONE.
  - Abort takes priority over `ctr_dn` in the same cycle.
- **DONE** (one cycle)
  - `done[g]`=1 and `gnt[g]` stays 1.
  - Next state is IDLE with `gnt` cleared and `ptr`←(g+1) mod `reqs`.
- `dly` is sampled only in IDLE; changes to `dly` after the grant are ignored.
- A requester that holds `req` after `done` is re-arbitrated normally, at lowest priority relative to `ptr`.
- Counter initialisation: while `rst`=1, `ctr_ld`=1 and `ctr_nb`=0 (combinational). This clears the counter, which has no reset of its own, so `ctr_dn` is known before first use.
- `ctr_nb`=0 whenever `ctr_ld`=0.
- `ctr_dn` is ignored outside WAIT. It stays high (sticky) until the next load, which is harmless.

## Timing
- Reset values: state IDLE, `gnt`=0, `done`=0, `busy`=0, `ptr`=0.
- Reset mid-operation: the job is dropped with no `done` pulse. The counter is re-cleared while `rst` is held.
- `gnt` rises 1 cycle after the IDLE cycle that sees `req`.
- `ctr_ld` is high in the first `gnt` cycle (the LOAD state).
- `done` is high exactly d+2 cycles after `gnt` rises, for one cycle. `gnt` falls the cycle after `done`.
- Job-to-job throughput is d+4 cycles (IDLE, LOAD, d+1 WAIT cycles, DONE) when requests are back-to-back.
- Boundaries:
  - k=0 gives d=`width` (`ctr_nb` all ones).
  - k=2^width−1 gives d=2^width+`width`−1 (`ctr_nb`=0).
  - `reqs`=1 makes `ptr` constant 0.
  - The `ptr` wrap from `reqs`−1 goes to 0.

## Test plan
- Reset: hold `rst` 3 cycles → `ctr_ld`=1, `ctr_nb`=0, `gnt`=0, `busy`=0 throughout. After release, `ctr_dn`=0.
- Single job (`width`=5, `reqs`=4): `req`=0001, k0=5 (d=10) → `gnt`=0001 at cycle c, `ctr_ld`/`ctr_nb`=11010 at c, `done`=0001 only at c+12, `gnt`=0 at c+13.
- Contention: `req`=1011 held with all k=0 → grant order 0,1,3,0,1,3. Each `done` comes 7 cycles after its `gnt` rises.
- Extremes: k=0 → `done` at `gnt`+7. k=31 → `done` at `gnt`+38.
- Abort: requester 2 (k=10) drops `req` 4 cycles after `gnt` → no `done`, `gnt` cleared next cycle. With `req`=1100, requester 3 is granted next.
- Reset mid-WAIT: `rst` pulsed during a d=20 job → no `done`, `ptr` back to 0. With `req`=1001, requester 0 is granted first.
